// File: rtl/cpu_pkg.sv
// Shared CPU definitions: width defaults, branch-condition codes, ALU opcodes
// and the condition-code register layout.
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;
  localparam int DEF_OP_W   = 6;

  // Branch conditions, evaluated against the N/Z/V register
  localparam logic [2:0] BR_NE = 3'b000;
  localparam logic [2:0] BR_EQ = 3'b001;
  localparam logic [2:0] BR_GT = 3'b010;
  localparam logic [2:0] BR_LT = 3'b011;
  localparam logic [2:0] BR_GE = 3'b100;
  localparam logic [2:0] BR_LE = 3'b101;
  localparam logic [2:0] BR_OV = 3'b110;
  localparam logic [2:0] BR_AL = 3'b111;

  // ALU opcodes of interest downstream (trace / trap cause)
  localparam logic [5:0] OP_SUB = 6'h02;
  localparam logic [5:0] OP_MUL = 6'h16;

  // Architectural condition codes
  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch resolution: condition code vs. current flag register.
module br_cond_eval
  import cpu_pkg::*;
(
  input  flags_t     flags,
  input  logic [2:0] cond,
  output logic       taken
);

  // Decode condition against N/Z/V
  always_comb begin
    taken = 1'b0;
    case (cond)
      BR_NE:   taken = !flags.z;
      BR_EQ:   taken = flags.z;
      BR_GT:   taken = !flags.z && !flags.n;
      BR_LT:   taken = flags.n;
      BR_GE:   taken = !flags.n;
      BR_LE:   taken = flags.n || flags.z;
      BR_OV:   taken = flags.v;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory stage: one-entry valid/ready buffer, architectural N/Z/V
// register and conditional branch resolution.
// Optional feature: define OVERFLOW_TRAP_EN to trap (and suppress writeback of)
// flag-setting instructions that overflow.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              ex_n,
  input  logic              ex_z,
  input  logic              ex_v,
  input  logic              ex_set_flags,
  input  logic              ex_wb_en,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_is_branch,
  input  logic [2:0]        ex_br_cond,
  input  logic [DATA_W-1:0] ex_br_target,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [RD_W-1:0]   mem_rd,
  output logic              mem_wb_en,
  output logic [OP_W-1:0]   mem_op,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              ovf_trap
);

  flags_t flags_q;
  logic   accept;
  logic   cond_true;
  logic   ovf_hit;

  assign ex_ready = !mem_valid || mem_ready;
  assign accept   = ex_valid && ex_ready && !flush;

  assign flag_n = flags_q.n;
  assign flag_z = flags_q.z;
  assign flag_v = flags_q.v;

  // Branch sees the flags as they stand before this instruction's own update
  br_cond_eval u_br_cond_eval (
    .flags (flags_q),
    .cond  (ex_br_cond),
    .taken (cond_true)
  );

`ifdef OVERFLOW_TRAP_EN
  assign ovf_hit = ex_set_flags && ex_v;
`else
  assign ovf_hit = 1'b0;
`endif

  // Buffer, flags and branch pulse; flush outranks accept and drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid   <= 1'b0;
      mem_alu_out <= '0;
      mem_rd      <= '0;
      mem_wb_en   <= 1'b0;
      mem_op      <= '0;
      flags_q     <= '0;
      br_taken    <= 1'b0;
      br_target   <= '0;
    end else begin
      br_taken <= 1'b0;
      if (flush) begin
        mem_valid <= 1'b0;
      end else if (accept) begin
        mem_valid   <= 1'b1;
        mem_alu_out <= ex_alu_out;
        mem_rd      <= ex_rd;
        mem_op      <= ex_op;
        // Branches never write rd; trapped overflows are not committed
        mem_wb_en   <= ex_wb_en && !ex_is_branch && !ovf_hit;
        if (ex_set_flags)
          flags_q <= '{n: ex_n, z: ex_z, v: ex_v};
        if (ex_is_branch && cond_true) begin
          br_taken  <= 1'b1;
          br_target <= ex_br_target;
        end
      end else if (mem_ready) begin
        mem_valid <= 1'b0;
      end
    end
  end

`ifdef OVERFLOW_TRAP_EN
  // One-cycle trap pulse for an accepted overflowing flag-setter
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_trap <= 1'b0;
    else        ovf_trap <= accept && ovf_hit;
  end
`else
  assign ovf_trap = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios followed by
// randomized traffic, compared every cycle against a transaction-level model.
module tb_ex_mem_stage;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int OP_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_valid, ex_ready;
  logic [OP_W-1:0]   ex_op;
  logic [DATA_W-1:0] ex_alu_out;
  logic              ex_n, ex_z, ex_v, ex_set_flags, ex_wb_en;
  logic [RD_W-1:0]   ex_rd;
  logic              ex_is_branch;
  logic [2:0]        ex_br_cond;
  logic [DATA_W-1:0] ex_br_target;
  logic              flush;
  logic              mem_valid, mem_ready;
  logic [DATA_W-1:0] mem_alu_out;
  logic [RD_W-1:0]   mem_rd;
  logic              mem_wb_en;
  logic [OP_W-1:0]   mem_op;
  logic              flag_n, flag_z, flag_v;
  logic              br_taken;
  logic [DATA_W-1:0] br_target;
  logic              ovf_trap;

  int tests = 0;
  int errs  = 0;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_alu_out(ex_alu_out), .ex_n(ex_n), .ex_z(ex_z), .ex_v(ex_v),
    .ex_set_flags(ex_set_flags), .ex_wb_en(ex_wb_en), .ex_rd(ex_rd),
    .ex_is_branch(ex_is_branch), .ex_br_cond(ex_br_cond),
    .ex_br_target(ex_br_target), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_out(mem_alu_out), .mem_rd(mem_rd), .mem_wb_en(mem_wb_en),
    .mem_op(mem_op), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
    .br_taken(br_taken), .br_target(br_target), .ovf_trap(ovf_trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference state
  bit          m_valid;
  bit [31:0]   m_alu;
  bit [4:0]    m_rd;
  bit          m_wb;
  bit [5:0]    m_op;
  bit          f_n, f_z, f_v;
  bit          m_bt;
  bit [31:0]   m_btgt;
  bit          m_ovf;

  function automatic bit cond_ok(bit [2:0] c, bit n, bit z, bit v);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit trap_on();
`ifdef OVERFLOW_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    bit acc, ovf;
    m_bt  = 0;
    m_ovf = 0;
    if (!rst_n) begin
      m_valid = 0; m_alu = 0; m_rd = 0; m_wb = 0; m_op = 0;
      f_n = 0; f_z = 0; f_v = 0; m_btgt = 0;
      return;
    end
    acc = ex_valid && (!m_valid || mem_ready) && !flush;
    ovf = trap_on() && ex_set_flags && ex_v;
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_alu = ex_alu_out; m_rd = ex_rd; m_op = ex_op;
      m_wb = ex_wb_en && !ex_is_branch && !ovf;
      m_ovf = ovf;
      if (ex_is_branch && cond_ok(ex_br_cond, f_n, f_z, f_v)) begin
        m_bt = 1; m_btgt = ex_br_target;
      end
      if (ex_set_flags) begin f_n = ex_n; f_z = ex_z; f_v = ex_v; end
    end else if (mem_ready) m_valid = 0;
  endtask

  // Inputs are already driven (we sit just after a negedge); clock one edge and compare
  task automatic step();
    #1 chk("ex_ready", ex_ready, !m_valid || mem_ready);
    @(posedge clk);
    model_edge();
    #1;
    chk("mem_valid", mem_valid, m_valid);
    if (m_valid) begin
      chk("mem_alu_out", mem_alu_out, m_alu);
      chk("mem_rd", mem_rd, m_rd);
      chk("mem_wb_en", mem_wb_en, m_wb);
      chk("mem_op", mem_op, m_op);
    end
    chk("flags", {flag_n, flag_z, flag_v}, {f_n, f_z, f_v});
    chk("br_taken", br_taken, m_bt);
    if (m_bt) chk("br_target", br_target, m_btgt);
    chk("ovf_trap", ovf_trap, m_ovf);
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1; ex_valid = 0; ex_op = 0; ex_alu_out = 0; ex_n = 0; ex_z = 0;
    ex_v = 0; ex_set_flags = 0; ex_wb_en = 0; ex_rd = 0; ex_is_branch = 0;
    ex_br_cond = 0; ex_br_target = 0; flush = 0; mem_ready = 1;
  endtask

  task automatic alu(input bit [5:0] op, input bit [31:0] v, input bit [4:0] rd,
                     input bit sf, input bit n, input bit z, input bit ov);
    idle();
    ex_valid = 1; ex_op = op; ex_alu_out = v; ex_rd = rd; ex_wb_en = 1;
    ex_set_flags = sf; ex_n = n; ex_z = z; ex_v = ov;
  endtask

  task automatic branch(input bit [2:0] c, input bit [31:0] tgt);
    idle();
    ex_valid = 1; ex_is_branch = 1; ex_br_cond = c; ex_br_target = tgt; ex_wb_en = 1;
  endtask

  initial begin
    @(negedge clk);
    // Reset
    idle(); rst_n = 0; step(); step();
    chk("rst_mem_alu_out", mem_alu_out, 0);
    chk("rst_mem_wb_en", mem_wb_en, 0);
    idle(); #1 chk("rst_ex_ready", ex_ready, 1);

    // Simple accept
    alu(6'h01, 32'd13284, 5'd3, 0, 1, 1, 1); step();
    chk("acc_alu_const", mem_alu_out, 32'd13284);
    chk("acc_rd_const", mem_rd, 3);

    // Stall two cycles with a second instruction pending
    alu(6'h01, 32'd111, 5'd4, 0, 0, 0, 0); step();
    alu(6'h01, 32'd222, 5'd5, 0, 0, 0, 0); mem_ready = 0; step(); step();
    chk("stall_hold", mem_alu_out, 32'd111);
    mem_ready = 1; step();
    chk("stall_second", mem_alu_out, 32'd222);
    idle(); step();

    // MUL sets Z, branch EQ taken, then NE not taken
    alu(cpu_pkg::OP_MUL, 32'd0, 5'd6, 1, 0, 1, 0); step();
    branch(3'b001, 32'h40); step();
    chk("beq_taken", br_taken, 1);
    chk("beq_target", br_target, 32'h40);
    idle(); step();
    branch(3'b000, 32'h80); step();
    chk("bne_not_taken", br_taken, 0);
    idle(); step();

    // Flush alongside a flag-setting accept
    alu(6'h03, 32'd5, 5'd7, 1, 1, 0, 0); flush = 1; step();
    chk("flush_n", flag_n, 0);
    idle(); step();

    // Overflowing SUB
    alu(cpu_pkg::OP_SUB, 32'h8000_0000 - 32'h7FFF_FFFF, 5'd8, 1, 0, 0, 1); step();
    chk("ovf_flag_v", flag_v, 1);
    chk("ovf_wb", mem_wb_en, !trap_on());
    chk("ovf_trap", ovf_trap, trap_on());
    idle(); step();

    // Reset mid-stall
    alu(6'h01, 32'd9, 5'd9, 0, 0, 0, 0); step();
    idle(); mem_ready = 0; step();
    rst_n = 0; step();
    chk("rst_stall_valid", mem_valid, 0);
    chk("rst_stall_alu", mem_alu_out, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(63) != 0);
      ex_valid     = ($urandom_range(3) != 0);
      ex_op        = 6'($urandom);
      ex_alu_out   = $urandom;
      ex_n         = 1'($urandom); ex_z = 1'($urandom); ex_v = 1'($urandom);
      ex_set_flags = 1'($urandom);
      ex_wb_en     = 1'($urandom);
      ex_rd        = 5'($urandom);
      ex_is_branch = ($urandom_range(2) == 0);
      ex_br_cond   = 3'($urandom);
      ex_br_target = $urandom;
      flush        = ($urandom_range(15) == 0);
      mem_ready    = ($urandom_range(3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage for the CPU, directly downstream of the ALU. It registers the ALU result, destination register and writeback enable into a one-entry valid/ready buffer. It also holds the architectural N/Z/V condition-code register and resolves conditional branches against it. It is the only place ALU flags become architectural state.

## Interface
- DATA_W, 32, ALU result / branch target width
- RD_W, 5, destination register index width
- OP_W, 6, ALU opcode width
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_op  in  OP_W  ALU opcode (passed through for trace/trap cause)
- ex_alu_out  in  DATA_W  ALU result
- ex_n, ex_z, ex_v  in  1 each  ALU flags for ex_alu_out
- ex_set_flags  in  1  instruction updates condition codes
- ex_wb_en  in  1  instruction writes rd
- ex_rd  in  RD_W  destination register
- ex_is_branch  in  1  conditional branch
- ex_br_cond  in  3  branch condition code
- ex_br_target  in  DATA_W  branch target address
- flush  in  1  squash buffered and incoming instruction
- mem_valid  out  1  buffered instruction valid
- mem_ready  in  1  memory stage consumes buffer
- mem_alu_out  out  DATA_W; mem_rd  out  RD_W; mem_wb_en  out  1; mem_op  out  OP_W
- flag_n, flag_z, flag_v  out  1 each  architectural condition codes
- br_taken  out  1  one-cycle pulse, branch resolved taken
- br_target  out  DATA_W  valid while br_taken=1
- ovf_trap  out  1  one-cycle overflow trap pulse (see Configuration)

## Operation
- ex_ready = !mem_valid || mem_ready (combinational). Accept = ex_valid && ex_ready && !flush.
- On accept: buffer loads ex_alu_out/ex_rd/ex_wb_en/ex_op, mem_valid<=1. Buffer drained without accept: mem_valid<=0. Unaccepted payload never changes buffer.
- On accept with ex_set_flags=1: flag_n/z/v <= ex_n/z/v. Flags are never written by flushed or unaccepted instructions.
- Branch condition, evaluated on accept against the flag register *before* this instruction's update: 000 NE(!Z), 001 EQ(Z), 010 GT(!Z&!N), 011 LT(N), 100 GE(!N), 101 LE(N|Z), 110 OV(V), 111 always.
- Accepted branch with condition true: br_taken=1, br_target=ex_br_target next cycle. Branches set mem_wb_en=0 regardless of ex_wb_en.
- flush=1: mem_valid<=0, incoming dropped, no flag update, br_taken/ovf_trap next cycle 0. Flush has priority over accept and drain.
- Arithmetic: none performed; all data passed bit-exact, flags unsigned-agnostic.

## Timing
- Reset (rst_n=0 at edge): mem_valid=0, mem_alu_out=0, mem_rd=0, mem_wb_en=0, mem_op=0, flags=000, br_taken=0, br_target=0, ovf_trap=0. ex_ready=1 immediately after.
- Latency 1 cycle ex->mem; full throughput when mem_ready=1 (accept and drain same cycle).
- mem_ready=0 with mem_valid=1: buffer and outputs hold; ex_ready=0.
- br_taken, ovf_trap: exactly one cycle, registered, cycle after accept.
- rst_n low mid-stall drops buffered instruction; no trap or branch emitted.

## Configuration
- OVERFLOW_TRAP_EN defined: accept with ex_set_flags=1 and ex_v=1 pulses ovf_trap next cycle and forces buffered mem_wb_en=0; flags still updated (V=1).
- Undefined: ovf_trap tied 0; overflowing result written back normally.

## Structure
- Shared cpu_pkg: branch-condition localparams (BR_NE..BR_AL), ALU opcode constants (OP_SUB=6'h02, OP_MUL=6'h16), DATA_W/RD_W defaults.
- One sub-module: br_cond_eval (combinational, flags + cond -> taken).

## Test plan
- Reset, then accept ex_alu_out=32'd13284 rd=3 wb_en=1 with mem_ready=1 -> next cycle mem_valid=1, mem_alu_out=13284, mem_rd=3; flags 000 (set_flags=0).
- mem_ready=0 two cycles with second instruction pending -> ex_ready=0, buffer holds first; mem_ready=1 -> second loads, no loss or duplicate.
- MUL with set_flags=1, z=1 then branch cond=001 target=32'h40 -> br_taken pulses one cycle, br_target=32'h40; same with cond=000 -> no pulse.
- Flush in same cycle as flag-setting accept with n=1 -> mem_valid=0, flag_n stays 0.
- SUB 32'h8000_0000-32'h7FFF_FFFF, v=1, set_flags=1 -> flag_v=1; with OVERFLOW_TRAP_EN ovf_trap pulses and mem_wb_en=0; without, ovf_trap=0 and mem_wb_en=1.
- rst_n low while mem_valid=1, mem_ready=0 -> all outputs at reset values next cycle.
